uart_rx_ctrl: RTL and testbench

//  Sequences the MiniUart receive unit: generates its 8x-oversample enable (en_rx), drains each

---
 rtl/uart_rx_ctrl_pkg.sv | 38 +++
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/uart_rx_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the MiniUart receive controller: register map,
// CTRL/STATUS bit positions, ack FSM encoding and the status count view.
package uart_rx_ctrl_pkg;

  // Register word offsets
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // CTRL bit positions (CLR and FLUSH are actions and read back as 0)
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_IE_BIT    = 2;
  localparam int CTRL_FLUSH_BIT = 3;

  // STATUS bit positions
  localparam int STAT_EMPTY_BIT = 4;
  localparam int STAT_FULL_BIT  = 5;
  localparam int STAT_OVR_BIT   = 6;
  localparam int STAT_DROP_LSB  = 8;

  // Reset value of the oversample divisor
  localparam logic [15:0] DEFAULT_DIV_VAL = 16'd26;

  // Handshake FSM with rx_unit
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } rx_state_t;

  // Four-bit count view: deep FIFOs saturate at 15, the full flag stays exact
  function automatic logic [3:0] count_view(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: circular buffer with push/pop/flush, combinational head.
// Pop of an empty FIFO and push into a full FIFO (without a coincident pop)
// are ignored; flush wins over any coincident push or pop.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array, written at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// MiniUart receive controller: oversample tick generator, rs synchroniser,
// byte-acknowledge FSM toward rx_unit, RX FIFO and CPU register file.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] DEFAULT_DIV = DEFAULT_DIV_VAL,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  output logic        en_rx,
  input  logic [7:0]  rx_data,
  input  logic        rx_rs,
  output logic        over_read,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // Configuration and status state
  logic [15:0] div_reg;
  logic [15:0] baud_cnt_reg;
  logic        en_rx_reg;
  logic        ctrl_en_reg;
  logic        ctrl_ie_reg;
  logic        overrun_reg;
  logic [7:0]  drop_cnt_reg;
  logic        rs_meta_reg;
  logic        rs_s_reg;
  logic        over_read_reg;
  rx_state_t   state_reg;

  // FIFO interface
  logic [7:0]  fifo_head;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;

  // Bus decode
  logic        wr_div;
  logic        wr_ctrl;
  logic        clr_err;
  logic        flush;
  logic        pop_this_cycle;
  logic        capture;
  logic        push_ok;
  logic        drop;

  assign wr_div         = we & (addr == ADDR_DIV);
  assign wr_ctrl        = we & (addr == ADDR_CTRL);
  assign clr_err        = wr_ctrl & wdata[CTRL_CLR_BIT];
  assign flush          = wr_ctrl & wdata[CTRL_FLUSH_BIT];
  assign fifo_pop       = rd & (addr == ADDR_DATA);
  assign pop_this_cycle = fifo_pop & ~fifo_empty;

  // A byte is taken from rx_unit on the IDLE->ACK transition; a pop in the
  // same cycle frees a slot so a full FIFO can still accept it.
  assign capture   = (state_reg == ST_IDLE) & rs_s_reg;
  assign push_ok   = ~fifo_full | pop_this_cycle;
  assign fifo_push = capture & push_ok;
  assign drop      = capture & ~push_ok;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Oversample tick: period DIV+1 while enabled; a DIV write restarts the period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_reg <= '0;
      en_rx_reg    <= 1'b0;
    end else if (wr_div || !ctrl_en_reg) begin
      baud_cnt_reg <= '0;
      en_rx_reg    <= 1'b0;
    end else if (baud_cnt_reg == div_reg) begin
      baud_cnt_reg <= '0;
      en_rx_reg    <= 1'b1;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 16'd1;
      en_rx_reg    <= 1'b0;
    end
  end

  // CPU-writable configuration: divisor, enable, interrupt enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg     <= DEFAULT_DIV;
      ctrl_en_reg <= 1'b0;
      ctrl_ie_reg <= 1'b0;
    end else begin
      if (wr_div) begin
        div_reg <= wdata[15:0];
      end
      if (wr_ctrl) begin
        ctrl_en_reg <= wdata[CTRL_EN_BIT];
        ctrl_ie_reg <= wdata[CTRL_IE_BIT];
      end
    end
  end

  // Overrun flag and saturating drop counter; a CPU clear wins over a new drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (clr_err) begin
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
      if (drop_cnt_reg != 8'hFF) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // Two-flop synchroniser for the rx_unit byte-ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_reg <= 1'b0;
      rs_s_reg    <= 1'b0;
    end else begin
      rs_meta_reg <= rx_rs;
      rs_s_reg    <= rs_meta_reg;
    end
  end

  // Acknowledge FSM: one over_read pulse per byte, then wait for rs to drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      over_read_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          over_read_reg <= 1'b0;
          if (rs_s_reg) begin
            state_reg     <= ST_ACK;
            over_read_reg <= 1'b1;
          end
        end
        ST_ACK: begin
          over_read_reg <= 1'b0;
          state_reg     <= ST_WAIT_CLR;
        end
        ST_WAIT_CLR: begin
          over_read_reg <= 1'b0;
          if (!rs_s_reg) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          over_read_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  // Register read mux; DATA shows the FIFO head, or zero when empty
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:   rdata = fifo_empty ? 32'd0 : {24'd0, fifo_head};
      ADDR_STATUS: rdata = {16'd0, drop_cnt_reg, 1'b0, overrun_reg, fifo_full,
                            fifo_empty, count_view(32'(fifo_count))};
      ADDR_DIV:    rdata = {16'd0, div_reg};
      ADDR_CTRL:   rdata = {29'd0, ctrl_ie_reg, 1'b0, ctrl_en_reg};
      default:     rdata = '0;
    endcase
  end

  assign en_rx     = en_rx_reg;
  assign over_read = over_read_reg;
  assign irq       = ctrl_ie_reg & ctrl_en_reg & ~fifo_empty;

  // Upper write-data bits have no register behind them
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:16]};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_rx;
  logic [7:0]  rx_data;
  logic        rx_rs;
  logic        over_read;
  logic [1:0]  addr;
  logic        we;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_ctrl #(
    .DEPTH       (DEPTH),
    .DEFAULT_DIV (16'd26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_rx     (en_rx),
    .rx_data   (rx_data),
    .rx_rs     (rx_rs),
    .over_read (over_read),
    .addr      (addr),
    .we        (we),
    .rd        (rd),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  logic        m_ovr;
  int          m_drop;
  logic [15:0] m_div;
  logic        m_en;
  logic        m_ie;
  logic        m_s1, m_s2, m_s3;
  int          m_phase;
  logic        m_en_rx;
  logic        m_or;
  bit          model_valid = 0;

  always @(posedge clk) begin
    bit pop_m;
    bit cap_m;
    if (rst) begin
      mq.delete();
      m_ovr = 0; m_drop = 0; m_div = 16'd26; m_en = 0; m_ie = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_phase = 0; m_en_rx = 0; m_or = 0;
      model_valid = 1;
    end else begin
      pop_m = rd && addr == 2'd0 && mq.size() > 0;
      // a byte is taken once per rising edge of the synchronised ready flag
      cap_m = m_s2 && !m_s3;
      // ticks fall on every (DIV+1)-th edge since enable or the last DIV write
      if (we && addr == 2'd2) begin
        m_phase = 0; m_en_rx = 0;
      end else if (!m_en) begin
        m_phase = 0; m_en_rx = 0;
      end else begin
        m_phase++;
        m_en_rx = (m_phase % (int'(m_div) + 1)) == 0;
      end
      m_or = cap_m;
      if (pop_m) void'(mq.pop_front());
      if (cap_m) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data);
        else begin
          m_ovr = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (we && addr == 2'd3) begin
        m_en = wdata[0];
        m_ie = wdata[2];
        if (wdata[1]) begin m_ovr = 0; m_drop = 0; end
        if (wdata[3]) mq.delete();
      end
      if (we && addr == 2'd2) m_div = wdata[15:0];
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = rx_rs;
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    int n;
    n = mq.size();
    case (a)
      2'd0: return (n > 0) ? {24'd0, mq[0]} : 32'd0;
      2'd1: return {16'd0, 8'(m_drop), 1'b0, m_ovr, (n == DEPTH), (n == 0),
                    (n > 15) ? 4'hF : 4'(n)};
      2'd2: return {16'd0, m_div};
      default: return {29'd0, m_ie, 1'b0, m_en};
    endcase
  endfunction

  // Compare DUT against the model shortly after every active edge
  always @(posedge clk) begin
    #2;
    if (model_valid) begin
      chk("en_rx", {31'd0, en_rx}, {31'd0, m_en_rx});
      chk("over_read", {31'd0, over_read}, {31'd0, m_or});
      chk("irq", {31'd0, irq}, {31'd0, m_ie & m_en & (mq.size() > 0)});
      chk("rdata", rdata, exp_rdata(addr));
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    $display("txn write addr=%0d data=%h", a, d);
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic pop, output logic [31:0] v);
    addr = a; rd = pop;
    #1 v = rdata;
    @(negedge clk);
    rd = 1'b0;
    $display("txn read addr=%0d pop=%0d data=%h", a, pop, v);
  endtask

  // Behaves like rx_unit: raise rs, drop it once acknowledged (unless hold)
  task automatic send_byte(input logic [7:0] d, input bit hold);
    int k;
    k = 0;
    rx_data = d; rx_rs = 1'b1;
    while (!over_read && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("over_read_latency", k, 3);
    if (!hold) begin
      rx_rs = 1'b0;
      tick(4);
    end
    $display("txn rx byte %h", d);
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!en_rx && k < 40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int k;
    rst = 1'b1; rx_data = '0; rx_rs = 1'b0; addr = '0; we = 1'b0; rd = 1'b0; wdata = '0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // 1: reset values, tick period, DIV restart
    rd_reg(2'd1, 1'b0, v); chk("reset_status", v, 32'h0000_0010);
    rd_reg(2'd2, 1'b0, v); chk("reset_div", v, 32'h0000_001A);
    chk("reset_en_rx", {31'd0, en_rx}, 32'd0);
    wr(2'd2, 32'd3);
    wr(2'd3, 32'h1);
    wait_tick(k); chk("first_tick", k, 4);
    wait_tick(k); chk("tick_period", k, 4);
    tick(1);
    wr(2'd2, 32'd3);
    wait_tick(k); chk("div_restart", k, 4);

    // 2: single byte, irq, DATA read
    wr(2'd3, 32'h5);
    send_byte(8'hA5, 0);
    rd_reg(2'd1, 1'b0, v); chk("one_byte_status", v, 32'h0000_0001);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd_reg(2'd0, 1'b1, v); chk("data_a5", v, 32'h0000_00A5);
    rd_reg(2'd1, 1'b0, v); chk("empty_after_read", v, 32'h0000_0010);
    chk("irq_clear", {31'd0, irq}, 32'd0);

    // 3: fill, overrun, drain, W1C
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    rd_reg(2'd1, 1'b0, v); chk("full_status", v, 32'h0000_002F);
    send_byte(8'hFF, 0);
    rd_reg(2'd1, 1'b0, v); chk("overrun_status", v, 32'h0000_016F);
    for (int i = 0; i < 16; i++) begin
      rd_reg(2'd0, 1'b1, v); chk("drain_order", v, 32'(i));
    end
    wr(2'd3, 32'h2);
    rd_reg(2'd1, 1'b0, v); chk("w1c_status", v, 32'h0000_0010);
    rd_reg(2'd3, 1'b0, v); chk("ctrl_after_w1c", v, 32'h0000_0000);
    wr(2'd3, 32'h5);

    // 4: full FIFO, byte lands in the same cycle as a DATA pop
    for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h10), 0);
    rx_data = 8'h77; rx_rs = 1'b1;
    tick(2);
    addr = 2'd0; rd = 1'b1;
    #1 chk("pop_with_push_head", rdata, 32'h0000_0010);
    @(negedge clk);
    rd = 1'b0;
    chk("pop_with_push_ack", {31'd0, over_read}, 32'd1);
    rx_rs = 1'b0;
    tick(4);
    rd_reg(2'd1, 1'b0, v); chk("pop_with_push_status", v, 32'h0000_002F);
    for (int i = 1; i < 16; i++) begin
      rd_reg(2'd0, 1'b1, v); chk("drain_after_pp", v, 32'(i + 16));
    end
    rd_reg(2'd0, 1'b1, v); chk("last_byte_77", v, 32'h0000_0077);

    // 5: empty read, then flush
    rd_reg(2'd0, 1'b1, v); chk("empty_read", v, 32'h0000_0000);
    rd_reg(2'd1, 1'b0, v); chk("empty_read_status", v, 32'h0000_0010);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 0);
    rd_reg(2'd1, 1'b0, v); chk("five_status", v, 32'h0000_0005);
    wr(2'd3, 32'hD);
    rd_reg(2'd1, 1'b0, v); chk("flush_status", v, 32'h0000_0010);

    // 6: reset while waiting for rs to clear, 3 bytes queued
    for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 0);
    rd_reg(2'd1, 1'b0, v); chk("three_status", v, 32'h0000_0003);
    send_byte(8'h44, 1);
    tick(1);
    rst = 1'b1; rx_rs = 1'b0; addr = 2'd1;
    #1;
    chk("rst_status", rdata, 32'h0000_0010);
    chk("rst_over_read", {31'd0, over_read}, 32'd0);
    chk("rst_en_rx", {31'd0, en_rx}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    addr = 2'd2;
    #1 chk("rst_div", rdata, 32'h0000_001A);
    tick(2);
    rst = 1'b0;
    tick(3);
    rd_reg(2'd1, 1'b0, v); chk("post_rst_status", v, 32'h0000_0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
